// File: rtl/mem_copy_dma_if.sv
// Data-memory port between the copy engine (master) and the memory (slave).
interface mem_copy_dma_if;
  localparam int unsigned DATA_W = 32;

  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/mem_copy_dma.sv
// Word-copy engine: copies len words from src to dst, one READ/WRITE pair per word.
// Optional running checksum of read words via MEM_COPY_CHECKSUM_EN. reset_i is async active-low.
module mem_copy_dma #(
  parameter int unsigned LEN_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [31:0]       src_addr_i,
  input  logic [31:0]       dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  mem_copy_dma_if.master    mem
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [31:0]       checksum_o
`endif
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   buf_q, buf_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  logic                misaligned;
  assign misaligned = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);

  // State, datapath and registered port outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef MEM_COPY_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Next state; port outputs are decoded from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (misaligned) begin
            err_d = 1'b1;
          end else begin
`ifdef MEM_COPY_CHECKSUM_EN
            csum_d = '0;
`endif
            if (len_i == '0) begin
              state_d = DONE;
            end else begin
              src_d   = src_addr_i;
              dst_d   = dst_addr_i;
              cnt_d   = len_i;
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        buf_d   = mem.rdata;
`ifdef MEM_COPY_CHECKSUM_EN
        csum_d  = csum_q + mem.rdata;
`endif
        state_d = WRITE;
      end
      WRITE: begin
        src_d   = src_q + ADDR_W'(4);
        dst_d   = dst_q + ADDR_W'(4);
        cnt_d   = cnt_q - LEN_W'(1);
        state_d = (cnt_q == LEN_W'(1)) ? DONE : READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rd_d    = (state_d == READ);
    wr_d    = (state_d == WRITE);
    busy_d  = rd_d || wr_d;
    done_d  = (state_d == DONE);
    addr_d  = rd_d ? src_d : (wr_d ? dst_d : '0);
    wdata_d = wr_d ? buf_d : '0;
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign mem.rd    = rd_q;
  assign mem.wr    = wr_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
`ifdef MEM_COPY_CHECKSUM_EN
  assign checksum_o = csum_q;
`endif

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: word-array memory, array-level copy model, per-cycle port checks.
module tb_mem_copy_dma;
  localparam int unsigned LEN_W = 16;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              start_i;
  logic [31:0]       src_addr_i;
  logic [31:0]       dst_addr_i;
  logic [LEN_W-1:0]  len_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0]       checksum_o;
`endif

  mem_copy_dma_if m ();

  mem_copy_dma #(.LEN_W(LEN_W)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .mem        (m.master)
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    .checksum_o (checksum_o)
`endif
  );

  always #5 clk = ~clk;

  // 256-word memory aliased on addr[9:2]; preload port used only while the engine is idle.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  always_comb m.rdata = m.rd ? mem[m.addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (m.wr) mem[m.addr[9:2]] <= m.wdata;
    else if (pre_we) mem[pre_idx] <= pre_val;
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] csum_exp = 32'h0;

  function automatic int unsigned ix(input logic [31:0] a);
    return {24'd0, a[9:2]};
  endfunction

  function automatic logic [68:0] vec(input logic b, input logic d, input logic e,
                                      input logic r, input logic w,
                                      input logic [31:0] a, input logic [31:0] wd);
    return {b, d, e, r, w, a, wd};
  endfunction

  function automatic logic [68:0] obs();
    return vec(busy_o, done_o, err_o, m.rd, m.wr, m.addr, m.wdata);
  endfunction

  task automatic chk(input string tag, input logic [68:0] o, input logic [68:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_csum(input string tag);
`ifdef MEM_COPY_CHECKSUM_EN
    chk(tag, {37'd0, checksum_o}, {37'd0, csum_exp});
`endif
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < 256; i++)
      chk($sformatf("%s mem[%0d]", tag, i), {37'd0, mem[i]}, {37'd0, ref_mem[i]});
  endtask

  task automatic poke(input int unsigned i, input logic [31:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = i[7:0]; pre_val = v;
    ref_mem[i] = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issue one command and check every port cycle until the block is back in IDLE.
  task automatic run_copy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                          input int n, input int pulse_k);
    logic [31:0] wexp[$];
    logic [31:0] w;
    logic [68:0] e;
    int total;
    int i;
    csum_exp = 32'h0;
    for (int j = 0; j < n; j++) begin
      w = ref_mem[ix(src + 32'(4 * j))];
      wexp.push_back(w);
      csum_exp = csum_exp + w;
      ref_mem[ix(dst + 32'(4 * j))] = w;
    end
    @(negedge clk);
    start_i = 1'b1; src_addr_i = src; dst_addr_i = dst; len_i = LEN_W'(n);
    @(posedge clk);
    total = (n == 0) ? 2 : 2 * n + 2;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (n == 0) begin
        e = (k == 1) ? vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0) : '0;
      end else if (k <= 2 * n) begin
        i = (k - 1) / 2;
        if (k % 2 == 1) e = vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, src + 32'(4 * i), 32'h0);
        else            e = vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, dst + 32'(4 * i), wexp[i]);
      end else if (k == 2 * n + 1) begin
        e = vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end else begin
        e = '0;
      end
      chk($sformatf("%s cyc%0d", tag, k), obs(), e);
      if (k == total - 1) chk_csum({tag, " csum@done"});
      start_i = (k == pulse_k);
      if (k == pulse_k) begin
        src_addr_i = $urandom; dst_addr_i = $urandom; len_i = LEN_W'($urandom_range(1, 9));
      end
    end
    start_i = 1'b0;
    chk_csum({tag, " csum"});
    chk_mem(tag);
  endtask

  task automatic run_err(input string tag, input logic [31:0] src, input logic [31:0] dst);
    @(negedge clk);
    start_i = 1'b1; src_addr_i = src; dst_addr_i = dst; len_i = LEN_W'(3);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " err pulse"}, obs(), vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0));
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, " err clear"}, obs(), '0);
    chk_csum({tag, " csum kept"});
    chk_mem(tag);
  endtask

  initial begin
    logic [31:0] s, d, w0;
    int n;
    reset_i = 1'b0; start_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
    pre_we = 1'b0; pre_idx = '0; pre_val = '0;

    // Random preload while held in reset.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_idx = 8'(i); pre_val = $urandom;
      ref_mem[i] = pre_val;
      if (i == 128) chk("reset outputs", obs(), '0);
    end
    @(negedge clk);
    pre_we = 1'b0;
    @(negedge clk);
    chk("reset outputs end", obs(), '0);
    chk_csum("reset csum");
    reset_i = 1'b1;
    @(negedge clk);
    chk("idle after reset", obs(), '0);

    poke(0, 32'h1111_1111);
    poke(1, 32'h2222_2222);
    run_copy("basic", 32'h0, 32'h8, 2, 0);

    run_copy("zero_len", 32'h40, 32'h80, 0, 0);

    run_err("mis_src", 32'h2, 32'h100);
    run_copy("after_err", 32'h100, 32'h200, 3, 0);
    run_err("mis_dst", 32'h10, 32'h101);

    run_copy("start_busy", 32'h20, 32'h300, 3, 2);

    // Reset in the second READ of a 4-word copy: only word 0 may land.
    s = 32'h240; d = 32'h280;
    w0 = ref_mem[ix(s)];
    ref_mem[ix(d)] = w0;
    @(negedge clk);
    start_i = 1'b1; src_addr_i = s; dst_addr_i = d; len_i = LEN_W'(4);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    chk("rst_mid read0", obs(), vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, s, 32'h0));
    @(negedge clk);
    chk("rst_mid write0", obs(), vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, d, w0));
    @(negedge clk);
    chk("rst_mid read1", obs(), vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, s + 32'h4, 32'h0));
    reset_i = 1'b0;
    #1;
    csum_exp = 32'h0;
    chk("rst_mid async clear", obs(), '0);
    chk_csum("rst_mid csum");
    @(negedge clk);
    chk("rst_mid held", obs(), '0);
    reset_i = 1'b1;
    @(negedge clk);
    chk("rst_mid idle", obs(), '0);
    @(negedge clk);
    chk("rst_mid idle2", obs(), '0);
    chk_mem("rst_mid");

    poke(255, 32'hCAFE_F00D);
    poke(0, 32'h0BAD_BEEF);
    run_copy("wrap", 32'hFFFF_FFFC, 32'h10, 2, 0);

    run_copy("overlap", 32'h180, 32'h184, 4, 0);

    for (int r = 0; r < 6; r++) begin
      s = $urandom; s[1:0] = 2'b00;
      d = $urandom; d[1:0] = 2'b00;
      n = $urandom_range(1, 5);
      run_copy($sformatf("rand%0d", r), s, d, n, 2 * $urandom_range(1, n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
